// File: rtl/tpu_tile_scheduler.sv
// tpu_tile_scheduler
//   Job-level sequencer for the TPU datapath. Accepts one matrix job (grid of
//   output tiles, inner length, base addresses) and walks every tile through
//   load -> compute -> drain -> write-back, generating per-tile addresses.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   job_start                   1-cycle pulse, accepted only while idle
//   job_rd_base/job_wr_base     first read / write-back address
//   job_tiles_r/job_tiles_c     tile grid (0 treated as 1)
//   job_k                       inner length per tile (0 treated as 1)
//   abort                       level, returns to idle at the next edge
//   read_start/read_done        queue-array load handshake
//   rd_addr/rd_size             tile read address and effective inner length
//   rempty/wfull                queue empty / full flags
//   compute_start               systolic enable, high through COMPUTE
//   write_start/write_done      write-back handshake
//   wr_addr                     tile write-back address
//   tile_row/tile_col           current tile position
//   busy/job_done/error         status: active, completion pulse, sticky timeout
module tpu_tile_scheduler #(
  parameter int datawith   = 16,
  parameter int array_size = 2,
  parameter int ADDR_W     = 10,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_start,
  input  logic [ADDR_W-1:0] job_rd_base,
  input  logic [ADDR_W-1:0] job_wr_base,
  input  logic [3:0]        job_tiles_r,
  input  logic [3:0]        job_tiles_c,
  input  logic [3:0]        job_k,
  input  logic              abort,
  output logic              read_start,
  input  logic              read_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        rd_size,
  input  logic              rempty,
  input  logic              wfull,
  output logic              compute_start,
  output logic              write_start,
  input  logic              write_done,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        tile_row,
  output logic [3:0]        tile_col,
  output logic              busy,
  output logic              job_done,
  output logic              error
);

  // Element width does not affect addressing; addresses step in elements.
  localparam int unused_data_w = datawith;

  localparam int WCW = $clog2(TIMEOUT + 2);
  localparam int CCW = 16;
  localparam logic [ADDR_W-1:0] WR_STEP = ADDR_W'(array_size * array_size);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_WRITE, S_NEXT, S_DONE
  } state_t;

  typedef struct packed {
    logic [3:0] tiles_r;
    logic [3:0] tiles_c;
    logic [3:0] k;
  } job_t;

  state_t          state;
  job_t            job;
  logic            issued;   // start pulse of the current LOAD/WRITE already sent
  logic [WCW-1:0]  wcnt;     // cycles spent waiting for read_done/write_done
  logic [CCW-1:0]  ccnt;     // compute cycle counter
  logic [CCW-1:0]  c_last;
  logic [3:0]      k_in, r_in, c_in;
  logic            last_tile, last_col;
  logic [ADDR_W-1:0] rd_step;

  assign k_in = (job_k == 4'd0) ? 4'd1 : job_k;
  assign r_in = (job_tiles_r == 4'd0) ? 4'd1 : job_tiles_r;
  assign c_in = (job_tiles_c == 4'd0) ? 4'd1 : job_tiles_c;

  // Compute lasts k + 3N - 2 cycles: k feed cycles plus array fill/flush skew.
  assign c_last    = CCW'(job.k) + CCW'(3 * array_size - 3);
  assign last_col  = (tile_col == job.tiles_c - 4'd1);
  assign last_tile = last_col && (tile_row == job.tiles_r - 4'd1);
  assign rd_step   = ADDR_W'(int'(job.k) * array_size);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      job           <= '0;
      issued        <= 1'b0;
      wcnt          <= '0;
      ccnt          <= '0;
      read_start    <= 1'b0;
      rd_addr       <= '0;
      rd_size       <= '0;
      compute_start <= 1'b0;
      write_start   <= 1'b0;
      wr_addr       <= '0;
      tile_row      <= '0;
      tile_col      <= '0;
      busy          <= 1'b0;
      job_done      <= 1'b0;
      error         <= 1'b0;
    end else begin
      read_start  <= 1'b0;
      write_start <= 1'b0;
      job_done    <= 1'b0;
      if (abort) begin
        state         <= S_IDLE;
        compute_start <= 1'b0;
        busy          <= 1'b0;
        issued        <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (job_start) begin
            job      <= '{tiles_r: r_in, tiles_c: c_in, k: k_in};
            rd_size  <= k_in;
            error    <= 1'b0;
            tile_row <= '0;
            tile_col <= '0;
            rd_addr  <= job_rd_base;
            wr_addr  <= job_wr_base;
            busy     <= 1'b1;
            // Pulse on the first LOAD cycle unless the queue is already full.
            state      <= S_LOAD;
            read_start <= ~wfull;
            issued     <= ~wfull;
            wcnt       <= '0;
          end
          S_LOAD: begin
            if (!issued) begin
              if (!wfull) begin
                read_start <= 1'b1;
                issued     <= 1'b1;
              end
            end else if (read_done) begin
              state         <= S_COMPUTE;
              compute_start <= 1'b1;
              ccnt          <= '0;
              issued        <= 1'b0;
            end else if (wcnt >= WCW'(TIMEOUT)) begin
              error  <= 1'b1;
              busy   <= 1'b0;
              issued <= 1'b0;
              state  <= S_IDLE;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
          S_COMPUTE: begin
            // Starved queue stalls the feed phase only; flush cycles never stall.
            if (!(rempty && (ccnt < CCW'(job.k)))) begin
              if (ccnt == c_last) begin
                compute_start <= 1'b0;
                state         <= S_DRAIN;
              end else begin
                ccnt <= ccnt + 1'b1;
              end
            end
          end
          S_DRAIN: begin
            state       <= S_WRITE;
            write_start <= 1'b1;
            issued      <= 1'b1;
            wcnt        <= '0;
          end
          S_WRITE: begin
            if (write_done) begin
              state  <= S_NEXT;
              issued <= 1'b0;
            end else if (wcnt >= WCW'(TIMEOUT)) begin
              error  <= 1'b1;
              busy   <= 1'b0;
              issued <= 1'b0;
              state  <= S_IDLE;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
          S_NEXT: begin
            if (last_tile) begin
              job_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              rd_addr  <= rd_addr + rd_step;
              wr_addr  <= wr_addr + WR_STEP;
              tile_col <= last_col ? 4'd0 : tile_col + 4'd1;
              tile_row <= last_col ? tile_row + 4'd1 : tile_row;
              state      <= S_LOAD;
              read_start <= ~wfull;
              issued     <= ~wfull;
              wcnt       <= '0;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Testbench for tpu_tile_scheduler: table of directed jobs, hand sequences for
// stalls / timeout / abort / reset, and randomized jobs against a tile-level model.
module tb_tpu_tile_scheduler;
  localparam int AW = 10;
  localparam int N  = 2;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst;
  logic job_start;
  logic [AW-1:0] job_rd_base, job_wr_base;
  logic [3:0] job_tiles_r, job_tiles_c, job_k;
  logic abort, read_start, read_done, rempty, wfull;
  logic compute_start, write_start, write_done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [3:0] rd_size, tile_row, tile_col;
  logic busy, job_done, error;

  tpu_tile_scheduler #(.datawith(16), .array_size(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .job_start(job_start), .job_rd_base(job_rd_base),
    .job_wr_base(job_wr_base), .job_tiles_r(job_tiles_r), .job_tiles_c(job_tiles_c),
    .job_k(job_k), .abort(abort), .read_start(read_start), .read_done(read_done),
    .rd_addr(rd_addr), .rd_size(rd_size), .rempty(rempty), .wfull(wfull),
    .compute_start(compute_start), .write_start(write_start), .write_done(write_done),
    .wr_addr(wr_addr), .tile_row(tile_row), .tile_col(tile_col), .busy(busy),
    .job_done(job_done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  typedef struct { int addr; int row; int col; int size; } rd_rec_t;
  rd_rec_t rd_q[$];
  int wr_q[$];
  int run_q[$];
  int run = 0, done_cnt = 0, done_cyc = 0, rs_cyc = 0, err_cyc = -1, start_cyc = 0;

  initial begin
    rd_rec_t r;
    forever begin
      @(negedge clk);
      if (read_start) begin
        r.addr = int'(rd_addr); r.row = int'(tile_row);
        r.col = int'(tile_col); r.size = int'(rd_size);
        rd_q.push_back(r);
        rs_cyc = cyc;
      end
      if (write_start) wr_q.push_back(int'(wr_addr));
      if (compute_start) run++;
      else if (run > 0) begin run_q.push_back(run); run = 0; end
      if (job_done) begin done_cnt++; done_cyc = cyc; end
      if (error && err_cyc < 0) err_cyc = cyc;
    end
  end

  // ---------------- handshake responders ----------------
  int rd_dly = 0, wr_dly = 0;
  bit rd_en = 1'b1;

  initial begin
    read_done = 1'b0;
    forever begin
      @(negedge clk);
      if (read_start && rd_en) begin
        repeat (rd_dly) @(posedge clk);
        @(posedge clk); #1 read_done = 1'b1;
        @(posedge clk); #1 read_done = 1'b0;
      end
    end
  end

  initial begin
    write_done = 1'b0;
    forever begin
      @(negedge clk);
      if (write_start) begin
        repeat (wr_dly) @(posedge clk);
        @(posedge clk); #1 write_done = 1'b1;
        @(posedge clk); #1 write_done = 1'b0;
      end
    end
  end

  task automatic clr();
    rd_q.delete(); wr_q.delete(); run_q.delete();
    done_cnt = 0; done_cyc = 0; err_cyc = -1; rs_cyc = 0;
  endtask

  // Call right after tick(); job_start is high for one cycle ("cycle 0").
  task automatic start_job(input int tr, input int tc, input int k, input int rb, input int wb);
    job_tiles_r = tr[3:0]; job_tiles_c = tc[3:0]; job_k = k[3:0];
    job_rd_base = rb[AW-1:0]; job_wr_base = wb[AW-1:0];
    job_start = 1'b1; start_cyc = cyc;
    tick();
    job_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int n = 0;
    @(negedge clk);
    while (busy && n < lim) begin @(negedge clk); n++; end
    chk({nm, " idle_timeout"}, busy, 0);
    tick(); tick();
  endtask

  task automatic wait_compute(input int nrd, input string nm);
    int n = 0;
    bit ok = 1'b0;
    while (!ok && n < 400) begin
      @(negedge clk); n++;
      ok = (rd_q.size() == nrd) && compute_start;
    end
    chk({nm, " reached_compute"}, ok, 1);
  endtask

  // Tile-level model: job shape -> expected address stream, tile order, timing.
  task automatic check_model(input string tag, input int tr, input int tc, input int k,
                             input int rb, input int wb, input int dr, input int dw);
    int er, ec, ek, t, l;
    er = (tr == 0) ? 1 : tr;
    ec = (tc == 0) ? 1 : tc;
    ek = (k == 0) ? 1 : k;
    t  = er * ec;
    l  = ek + 3 * N - 2;
    chk({tag, " latency"}, done_cyc - start_cyc, t * (l + 6 + dr + dw) + 1);
    chk({tag, " n_reads"}, rd_q.size(), t);
    chk({tag, " n_writes"}, wr_q.size(), t);
    chk({tag, " n_runs"}, run_q.size(), t);
    chk({tag, " done_cnt"}, done_cnt, 1);
    for (int i = 0; i < t; i++) begin
      if (i < rd_q.size()) begin
        chk($sformatf("%s rd_addr[%0d]", tag, i), rd_q[i].addr, (rb + i * ek * N) % 1024);
        chk($sformatf("%s row[%0d]", tag, i), rd_q[i].row, i / ec);
        chk($sformatf("%s col[%0d]", tag, i), rd_q[i].col, i % ec);
        chk($sformatf("%s rd_size[%0d]", tag, i), rd_q[i].size, ek);
      end
      if (i < wr_q.size())
        chk($sformatf("%s wr_addr[%0d]", tag, i), wr_q[i], (wb + i * N * N) % 1024);
      if (i < run_q.size())
        chk($sformatf("%s compute_len[%0d]", tag, i), run_q[i], l);
    end
  endtask

  typedef struct {
    int tr, tc, k, rb, wb;
    int lat, nrd, first_rd, last_rd, last_wr, size, runl;
  } vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{1, 1, 4,  'h010, 'h200, 15, 1, 'h010, 'h010, 'h200, 4,  8};
    tbl[1] = '{2, 3, 2,  'h000, 'h100, 73, 6, 'h000, 'h014, 'h114, 2,  6};
    tbl[2] = '{1, 2, 4,  'h3FC, 'h000, 29, 2, 'h3FC, 'h004, 'h004, 4,  8};
    tbl[3] = '{0, 0, 0,  'h055, 'h0AA, 12, 1, 'h055, 'h055, 'h0AA, 1,  5};
    tbl[4] = '{3, 1, 15, 'h100, 'h3F8, 76, 3, 'h100, 'h13C, 'h000, 15, 19};

    job_start = 0; job_rd_base = 0; job_wr_base = 0;
    job_tiles_r = 0; job_tiles_c = 0; job_k = 0;
    abort = 0; rempty = 0; wfull = 0;
    rst = 0;
    #1 rst = 1;
    #1;
    chk("reset ctrl", {read_start, compute_start, write_start, busy, job_done, error}, 0);
    chk("reset addr", {rd_addr, wr_addr}, 0);
    chk("reset tile", {rd_size, tile_row, tile_col}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tick();

    // Directed table, ideal handshakes.
    for (int v = 0; v < 5; v++) begin
      string tg;
      tg = $sformatf("tbl%0d", v);
      clr();
      start_job(tbl[v].tr, tbl[v].tc, tbl[v].k, tbl[v].rb, tbl[v].wb);
      wait_idle(tg, 2000);
      chk({tg, " lat"}, done_cyc - start_cyc, tbl[v].lat);
      chk({tg, " nrd"}, rd_q.size(), tbl[v].nrd);
      chk({tg, " first_rd"}, (rd_q.size() > 0) ? rd_q[0].addr : 9999, tbl[v].first_rd);
      chk({tg, " last_rd"}, (rd_q.size() > 0) ? rd_q[rd_q.size()-1].addr : 9999, tbl[v].last_rd);
      chk({tg, " last_wr"}, (wr_q.size() > 0) ? wr_q[wr_q.size()-1] : 9999, tbl[v].last_wr);
      chk({tg, " size"}, (rd_q.size() > 0) ? rd_q[0].size : 9999, tbl[v].size);
      chk({tg, " run"}, (run_q.size() > 0) ? run_q[0] : 9999, tbl[v].runl);
      chk({tg, " busy_after"}, busy, 0);
      check_model(tg, tbl[v].tr, tbl[v].tc, tbl[v].k, tbl[v].rb, tbl[v].wb, 0, 0);
    end

    // wfull stall at LOAD entry, then rempty stall early in COMPUTE.
    clr();
    wfull = 1'b1;
    start_job(1, 1, 4, 'h010, 'h200);
    repeat (4) tick();
    wfull = 1'b0;
    wait_compute(1, "stall");
    tick();
    rempty = 1'b1;
    repeat (3) tick();
    rempty = 1'b0;
    wait_idle("stall", 500);
    chk("stall read_start_cycle", rs_cyc - start_cyc, 6);
    chk("stall compute_len", (run_q.size() > 0) ? run_q[0] : 9999, 11);
    chk("stall latency", done_cyc - start_cyc, 23);
    chk("stall done_cnt", done_cnt, 1);

    // read_done never comes: timeout.
    clr();
    rd_en = 1'b0;
    start_job(1, 1, 4, 'h000, 'h000);
    wait_idle("timeout", 600);
    chk("timeout wait_cycles", err_cyc - rs_cyc, 256);
    chk("timeout error", error, 1);
    chk("timeout no_done", done_cnt, 0);
    chk("timeout n_reads", rd_q.size(), 1);
    rd_en = 1'b1;
    clr();
    start_job(1, 1, 4, 'h030, 'h060);
    @(negedge clk);
    chk("error cleared", error, 0);
    wait_idle("post_timeout", 500);
    check_model("post_timeout", 1, 1, 4, 'h030, 'h060, 0, 0);

    // job_start while busy is ignored; abort during compute of tile 2.
    clr();
    start_job(1, 3, 4, 'h040, 'h080);
    wait_compute(1, "abort t1");
    tick();
    job_rd_base = 'h2AA; job_tiles_r = 4'd5; job_start = 1'b1;
    tick();
    job_start = 1'b0;
    wait_compute(2, "abort t2");
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort compute_start", compute_start, 0);
    repeat (30) tick();
    chk("abort no_done", done_cnt, 0);
    chk("abort error", error, 0);
    chk("abort n_reads", rd_q.size(), 2);
    chk("abort rd_addr[1]", (rd_q.size() > 1) ? rd_q[1].addr : 9999, 'h048);
    chk("abort col[1]", (rd_q.size() > 1) ? rd_q[1].col : 9999, 1);

    // Asynchronous reset in the middle of WRITE.
    clr();
    start_job(1, 1, 4, 'h123, 'h321);
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!write_start && n < 200);
    end
    chk("rst reached_write", write_start, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_write outputs",
        {read_start, compute_start, write_start, busy, job_done, error,
         rd_addr, wr_addr, rd_size, tile_row, tile_col}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) tick();

    // Randomized jobs with random handshake latency.
    for (int j = 0; j < 8; j++) begin
      int tr, tc, k, rb, wb;
      tr = $urandom_range(0, 3); tc = $urandom_range(0, 3); k = $urandom_range(0, 15);
      rb = $urandom_range(0, 1023); wb = $urandom_range(0, 1023);
      rd_dly = $urandom_range(0, 3); wr_dly = $urandom_range(0, 3);
      clr();
      start_job(tr, tc, k, rb, wb);
      wait_idle($sformatf("rnd%0d", j), 3000);
      check_model($sformatf("rnd%0d", j), tr, tc, k, rb, wb, rd_dly, wr_dly);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
